apb_master_arb: RTL and testbench

- Multi-requester APB master. Arbitrates N local requesters round-robin onto one APB bus (pwrite/psel/pen/paddr/pwdata out; pready/prdata in).
- Sequences each transfer through the SETUP and ACCESS phases and returns read data or a timeout error to the winning requester.
- Sits between on-chip initiators (sequencers, config engines) and the APB slave side of the 8-bit APB subsystem.

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_rr_arbiter.sv | 47 ++++
 rtl/apb_master_arb.sv | 117 +++++++++++
 tb/tb_apb_master_arb.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and default widths for the multi-requester APB master.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 8;
  localparam int unsigned APB_DATA_W = 8;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning upward from a rotating pointer.
module apb_rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic                     pclk,
  input  logic                     prst,
  input  logic [N_REQ-1:0]         req,
  input  logic                     advance,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] ptr_q;
  logic             found;
  int unsigned      cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      cand = (int'(ptr_q) + off) % N_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  // Pointer moves to just past the winner so it has lowest priority next time.
  always_ff @(posedge pclk) begin
    if (prst) begin
      ptr_q <= '0;
    end else if (advance && found) begin
      if (grant_idx == IDX_W'(N_REQ - 1)) begin
        ptr_q <= '0;
      end else begin
        ptr_q <= grant_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// APB master that arbitrates N local requesters round-robin onto a single APB bus
// and returns read data or a timeout error to the winner.
module apb_master_arb
  import apb_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned ADDR_W   = APB_ADDR_W,
  parameter int unsigned DATA_W   = APB_DATA_W,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic                    pclk,
  input  logic                    prst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_write,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    psel,
  output logic                    pen,
  output logic                    pwrite,
  output logic [ADDR_W-1:0]       paddr,
  output logic [DATA_W-1:0]       pwdata,
  input  logic                    pready,
  input  logic [DATA_W-1:0]       prdata
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  apb_state_e       state_q;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] owner_q;
  logic [IDX_W-1:0] grant_idx;
  logic [7:0]       wait_q;
  logic             idle_ok;
  logic             take;

  assign idle_ok   = (state_q == APB_IDLE) && !prst;
  assign take      = idle_ok && (|req_valid);
  assign req_ready = idle_ok ? grant : '0;

  apb_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .pclk      (pclk),
    .prst      (prst),
    .req       (req_valid),
    .advance   (take),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q   <= APB_IDLE;
      owner_q   <= '0;
      wait_q    <= '0;
      psel      <= 1'b0;
      pen       <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      busy      <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      unique case (state_q)
        APB_IDLE: begin
          if (take) begin
            // paddr/pwdata/pwrite double as the request latch.
            pwrite  <= req_write[grant_idx];
            paddr   <= req_addr[grant_idx*ADDR_W +: ADDR_W];
            pwdata  <= req_wdata[grant_idx*DATA_W +: DATA_W];
            owner_q <= grant;
            wait_q  <= '0;
            psel    <= 1'b1;
            pen     <= 1'b0;
            busy    <= 1'b1;
            state_q <= APB_SETUP;
          end
        end
        APB_SETUP: begin
          pen     <= 1'b1;
          state_q <= APB_ACCESS;
        end
        APB_ACCESS: begin
          if (pready) begin
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= 1'b0;
            rsp_valid <= owner_q;
            psel      <= 1'b0;
            pen       <= 1'b0;
            busy      <= 1'b0;
            state_q   <= APB_IDLE;
          end else if (wait_q == 8'(WAIT_MAX - 1)) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= owner_q;
            psel      <= 1'b0;
            pen       <= 1'b0;
            busy      <= 1'b0;
            state_q   <= APB_IDLE;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        default: state_q <= APB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb with a grant-order queue and a response scoreboard.
module tb_apb_master_arb;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int WM = 15;

  logic            pclk = 1'b0;
  logic            prst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            busy;
  logic            psel;
  logic            pen;
  logic            pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic            pready;
  logic [DW-1:0]   prdata;

  logic [AW-1:0] r_addr[N];
  logic [DW-1:0] r_wdata[N];
  logic          r_write[N];
  int            rem[N];

  int            slave_waits = 0;
  logic [DW-1:0] slave_rdata = '0;
  int            acc_cnt = 0;

  typedef struct {
    int            idx;
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  rsp_t sb[$];
  int   gq[$];

  logic [AW-1:0] cur_addr  = '0;
  logic [DW-1:0] cur_wdata = '0;
  logic          cur_write = 1'b0;
  bit            cur_vld   = 1'b0;
  int            mon_g;
  rsp_t          mon_r;

  int checks   = 0;
  int failures = 0;

  apb_master_arb #(
    .N_REQ    (N),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .WAIT_MAX (WM)
  ) dut (
    .pclk      (pclk),
    .prst      (prst),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .psel      (psel),
    .pen       (pen),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pready    (pready),
    .prdata    (prdata)
  );

  always #5 pclk = ~pclk;

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign req_addr[gi*AW +: AW]  = r_addr[gi];
    assign req_wdata[gi*DW +: DW] = r_wdata[gi];
    assign req_write[gi]          = r_write[gi];
  end

  // Slave: pready after slave_waits low ACCESS cycles; prdata is junk when not ready.
  always @(posedge pclk) begin
    if (psel && pen && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end
  assign pready = psel && pen && (acc_cnt == slave_waits);
  assign prdata = pready ? slave_rdata : 8'hEE;

  // Requesters keep valid high while they still have transfers outstanding.
  always @(posedge pclk) begin
    #1;
    for (int i = 0; i < N; i++) req_valid[i] = (rem[i] != 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge pclk) begin
    if (psel && cur_vld) begin
      chk("bus_addr_stable", 32'(paddr), 32'(cur_addr));
      chk("bus_wdata_stable", 32'(pwdata), 32'(cur_wdata));
      chk("bus_write_stable", 32'(pwrite), 32'(cur_write));
    end
    if (req_ready != '0) begin
      mon_g = -1;
      for (int i = 0; i < N; i++) if (req_ready[i]) mon_g = i;
      chk("grant_onehot", 32'($onehot(req_ready)), 32'd1);
      if (gq.size() == 0) begin
        chk("grant_unexpected", 32'(req_ready), 32'd0);
      end else begin
        chk("grant_order", 32'(mon_g), 32'(gq.pop_front()));
      end
      if (mon_g >= 0) begin
        mon_r.idx   = mon_g;
        mon_r.err   = (slave_waits >= WM);
        mon_r.rdata = (mon_r.err || r_write[mon_g]) ? '0 : slave_rdata;
        sb.push_back(mon_r);
        cur_addr  = r_addr[mon_g];
        cur_wdata = r_wdata[mon_g];
        cur_write = r_write[mon_g];
        cur_vld   = 1'b1;
        rem[mon_g]--;
      end
    end
    if (rsp_valid != '0) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        mon_r = sb.pop_front();
        chk("rsp_idx", 32'(rsp_valid), 32'd1 << mon_r.idx);
        chk("rsp_rdata", 32'(rsp_rdata), 32'(mon_r.rdata));
        chk("rsp_err", 32'(rsp_err), 32'(mon_r.err));
      end
    end
  end

  task automatic wait_gnt(input int i, input string tag);
    int n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (!req_ready[i] && n < 50);
    chk(tag, 32'(req_ready[i]), 32'd1);
  endtask

  // Called at the grant negedge; returns ACCESS cycles seen until psel drops.
  task automatic count_access(output int c);
    int n = 0;
    c = 0;
    do begin
      @(negedge pclk);
      n++;
      if (psel && pen) c++;
    end while ((psel || n < 2) && n < 80);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while ((sb.size() != 0 || gq.size() != 0 || busy || req_valid != '0) && n < 400);
    chk({tag, "_bound"}, 32'(n < 400), 32'd1);
    chk({tag, "_drained"}, 32'(sb.size() + gq.size()), 32'd0);
  endtask

  initial begin
    int c;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int i = 0; i < N; i++) begin
      r_addr[i]  = '0;
      r_wdata[i] = '0;
      r_write[i] = 1'b0;
      rem[i]     = 0;
    end

    // Reset state
    prst = 1'b1;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_pen", 32'(pen), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp", 32'({rsp_err, rsp_rdata}), 32'd0);
    chk("rst_bus", 32'({pwrite, paddr, pwdata}), 32'd0);
    prst = 1'b0;

    // Single write, zero wait states
    r_write[0] = 1'b1;
    r_addr[0]  = 8'h10;
    r_wdata[0] = 8'hA5;
    slave_waits = 0;
    gq.push_back(0);
    rem[0] = 1;
    wait_gnt(0, "wr_grant");
    chk("wr_grant_vec", 32'(req_ready), 32'h1);
    @(negedge pclk);
    chk("wr_setup_ctl", 32'({psel, pen, busy}), 32'b101);
    chk("wr_setup_bus", 32'({pwrite, paddr, pwdata}), 32'h110A5);
    @(negedge pclk);
    chk("wr_access_ctl", 32'({psel, pen}), 32'b11);
    @(negedge pclk);
    chk("wr_rsp", 32'({rsp_valid, rsp_err}), 32'b00010);
    chk("wr_released", 32'({psel, pen, busy}), 32'd0);
    wait_done("wr");

    // Read with three wait states; requester scribbles on its fields after the grant
    r_write[1]   = 1'b0;
    r_addr[1]    = 8'h22;
    r_wdata[1]   = 8'h00;
    slave_waits  = 3;
    slave_rdata  = 8'h5C;
    gq.push_back(1);
    rem[1] = 1;
    wait_gnt(1, "rd_grant");
    @(posedge pclk);
    #1;
    r_addr[1]  = 8'hFF;
    r_wdata[1] = 8'h77;
    r_write[1] = 1'b1;
    count_access(c);
    chk("rd_access_cycles", 32'(c), 32'd4);
    chk("rd_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), {23'd0, 4'b0010, 1'b0, 8'h5C});
    wait_done("rd");

    // Reset the pointer, then fairness with all four requesters
    @(negedge pclk);
    prst = 1'b1;
    @(negedge pclk);
    prst = 1'b0;
    slave_waits = 0;
    slave_rdata = 8'h96;
    for (int i = 0; i < N; i++) begin
      r_addr[i]  = 8'(8'h40 + i);
      r_wdata[i] = 8'(8'hC0 + i);
      r_write[i] = i[0];
    end
    for (int k = 0; k < 8; k++) gq.push_back(k % 4);
    gq.push_back(0);
    gq.push_back(2);
    gq.push_back(0);
    gq.push_back(2);
    rem[0] = 4;
    rem[1] = 2;
    rem[2] = 4;
    rem[3] = 2;
    wait_done("rr");

    // Timeout with pready stuck low, then a normal read
    slave_waits = 255;
    r_write[2]  = 1'b0;
    r_addr[2]   = 8'h33;
    gq.push_back(2);
    rem[2] = 1;
    wait_gnt(2, "to_grant");
    count_access(c);
    chk("to_access_cycles", 32'(c), 32'd15);
    chk("to_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), {23'd0, 4'b0100, 1'b1, 8'h00});
    wait_done("to");
    slave_waits = 0;
    slave_rdata = 8'h3C;
    r_write[3]  = 1'b0;
    r_addr[3]   = 8'h44;
    gq.push_back(3);
    rem[3] = 1;
    wait_done("post_to");
    chk("post_to_hold", 32'({rsp_err, rsp_rdata}), 32'h03C);

    // Reset in the middle of req3's ACCESS phase
    slave_waits = 255;
    gq.push_back(3);
    rem[3] = 1;
    wait_gnt(3, "mid_grant");
    @(negedge pclk);
    @(negedge pclk);
    chk("mid_in_access", 32'({psel, pen}), 32'b11);
    prst = 1'b1;
    sb.delete();
    cur_vld = 1'b0;
    @(negedge pclk);
    chk("mid_released", 32'({psel, pen, busy}), 32'd0);
    chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
    slave_waits = 0;
    slave_rdata = 8'h81;
    r_write[0]  = 1'b0;
    r_addr[0]   = 8'h50;
    rem[3] = 1;
    rem[0] = 1;
    gq.push_back(0);
    gq.push_back(3);
    repeat (2) @(negedge pclk);
    prst = 1'b0;
    wait_done("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
